mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/SoC_pkg.sv | 7 +
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/rr_arb2.sv | 16 +
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/SoC_pkg.sv
// Shared widths and FSM state type for the memory port arbiter.
package SoC_pkg;
    localparam int unsigned WORD_WIDTH  = 4;
    localparam int unsigned INDEX_WIDTH = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory signals of the arbiter. slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_WIDTH  = SoC_pkg::WORD_WIDTH,
    parameter int unsigned INDEX_WIDTH = SoC_pkg::INDEX_WIDTH
);
    logic [1:0]               req_i;
    logic [1:0]               we_i;
    logic [2*INDEX_WIDTH-1:0] index_i;
    logic [2*WORD_WIDTH-1:0]  wdata_i;
    logic [1:0]               done_o;
    logic [1:0]               err_o;
    logic [WORD_WIDTH-1:0]    rdata_o;
    logic                     wr_o;
    logic                     rd_o;
    logic                     ack_wr_i;
    logic                     ack_rd_i;
    logic [WORD_WIDTH-1:0]    wr_data_o;
    logic [INDEX_WIDTH-1:0]   wr_index_o;
    logic [INDEX_WIDTH-1:0]   rd_index_o;
    logic [WORD_WIDTH-1:0]    rd_data_i;

    modport slave (
        input  req_i, we_i, index_i, wdata_i, ack_wr_i, ack_rd_i, rd_data_i,
        output done_o, err_o, rdata_o, wr_o, rd_o, wr_data_o, wr_index_o, rd_index_o
    );

    modport master (
        output req_i, we_i, index_i, wdata_i, ack_wr_i, ack_rd_i, rd_data_i,
        input  done_o, err_o, rdata_o, wr_o, rd_o, wr_data_o, wr_index_o, rd_index_o
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to the pointer.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto a single memory port with a per-transaction ack timeout.
module mem_port_arbiter #(
    parameter int unsigned WORD_WIDTH     = SoC_pkg::WORD_WIDTH,
    parameter int unsigned INDEX_WIDTH    = SoC_pkg::INDEX_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    mem_port_arbiter_if.slave    bus
);
    import SoC_pkg::state_e, SoC_pkg::StIdle, SoC_pkg::StIssue, SoC_pkg::StResp;

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   sel_q, sel_d;
    logic                   we_q, we_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [1:0]             gnt;
    logic                   ack;

    rr_arb2 u_rr_arb2 (
        .req_i (bus.req_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign ack = we_q ? bus.ack_wr_i : bus.ack_rd_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        index_d = index_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    sel_d   = gnt[1];
                    we_d    = gnt[1] ? bus.we_i[1] : bus.we_i[0];
                    index_d = gnt[1] ? bus.index_i[2*INDEX_WIDTH-1:INDEX_WIDTH]
                                     : bus.index_i[INDEX_WIDTH-1:0];
                    wdata_d = gnt[1] ? bus.wdata_i[2*WORD_WIDTH-1:WORD_WIDTH]
                                     : bus.wdata_i[WORD_WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // An ack in the timeout cycle still wins over the timeout.
                if (ack) begin
                    if (!we_q) rdata_d = bus.rd_data_i;
                    ptr_d   = ~sel_q;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    ptr_d   = ~sel_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.wr_o       = (state_q == StIssue) &&  we_q;
    assign bus.rd_o       = (state_q == StIssue) && !we_q;
    assign bus.wr_index_o = index_q;
    assign bus.rd_index_o = index_q;
    assign bus.wr_data_o  = wdata_q;
    assign bus.rdata_o    = rdata_q;
    // sel_q is still valid in the cycle after a timeout, so it steers the err pulse too.
    assign bus.done_o     = (state_q == StResp) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.err_o      = err_q ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
endmodule
